// File: rtl/diamond_pkg.sv
// diamond_pkg: shared definitions for the diamond pattern byte stream.
//   CH_SPACE / CH_STAR / CH_NL : ASCII bytes making up the pattern
//   state_t                    : generator FSM states
//   diamond_len(n)             : total bytes emitted for pattern size n
//   state_byte(s)              : byte presented while the FSM sits in state s
//   state_emits(s)             : state s presents a byte on the stream
package diamond_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_NL    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    SPACE,
    STAR,
    GAP,
    NL,
    DONE
  } state_t;

  // For n=0 the (n-1) term wraps, but it is multiplied by zero.
  function automatic int unsigned diamond_len(input int unsigned n);
    return 2 * (n * (n + 2) + (n * (n - 1)) / 2);
  endfunction

  function automatic logic [7:0] state_byte(input state_t s);
    case (s)
      SPACE, GAP: return CH_SPACE;
      STAR:       return CH_STAR;
      NL:         return CH_NL;
      default:    return 8'h00;
    endcase
  endfunction

  function automatic logic state_emits(input state_t s);
    return (s == SPACE) || (s == STAR) || (s == GAP) || (s == NL);
  endfunction

endpackage

// File: rtl/diamond_char_gen.sv
// diamond_char_gen: emits the ASCII diamond star pattern as a valid/ready
// byte stream, one byte per cycle while the sink is ready.
//   clk, rst        : clock, synchronous active-high reset
//   start, n        : one-cycle request and pattern size (sampled when idle)
//   m_data, m_valid : registered output byte and its valid flag
//   m_ready         : sink accepts the byte when m_valid && m_ready
//   busy            : pattern in progress (includes the DONE cycle)
//   done            : one-cycle pulse after the final newline is accepted
module diamond_char_gen
  import diamond_pkg::*;
#(
  parameter int unsigned N_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n,
  output logic [7:0]     m_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           busy,
  output logic           done
);

  state_t         state, state_nx;
  logic [N_W-1:0] n_reg, n_nx;
  logic [N_W-1:0] row, row_nx;
  logic [N_W-1:0] col, col_nx;
  logic           half, half_nx;

  logic           adv;
  logic [N_W-1:0] sp_cur;
  logic [N_W-1:0] pr_cur;

  // Leading spaces of a row. Upper rows hold i (n-1-i spaces); lower rows
  // hold k (n-k spaces).
  function automatic logic [N_W-1:0] row_space(input logic [N_W-1:0] nv,
                                               input logic [N_W-1:0] rv,
                                               input logic           hv);
    return hv ? (nv - rv) : (nv - rv - N_W'(1));
  endfunction

  assign adv    = m_valid && m_ready;
  assign sp_cur = row_space(n_reg, row, half);
  assign pr_cur = half ? row : (row + N_W'(1));

  always_comb begin
    state_nx = state;
    n_nx     = n_reg;
    row_nx   = row;
    col_nx   = col;
    half_nx  = half;
    case (state)
      IDLE: begin
        if (start) begin
          n_nx    = n;
          row_nx  = '0;
          col_nx  = '0;
          half_nx = 1'b0;
          if (n == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = (row_space(n, '0, 1'b0) == '0) ? STAR : SPACE;
          end
        end
      end
      SPACE: begin
        if (adv) begin
          if (col + N_W'(1) == sp_cur) begin
            col_nx   = '0;
            state_nx = STAR;
          end else begin
            col_nx = col + N_W'(1);
          end
        end
      end
      STAR: begin
        if (adv) state_nx = GAP;
      end
      GAP: begin
        // col counts completed "* " pairs in the current row.
        if (adv) begin
          if (col + N_W'(1) == pr_cur) begin
            col_nx   = '0;
            state_nx = NL;
          end else begin
            col_nx   = col + N_W'(1);
            state_nx = STAR;
          end
        end
      end
      NL: begin
        if (adv) begin
          if (half && (row == N_W'(1))) begin
            row_nx   = '0;
            half_nx  = 1'b0;
            state_nx = DONE;
          end else begin
            // The widest row repeats: the last upper row (i=n-1) hands over
            // to the first lower row (k=n).
            if (!half && (row == n_reg - N_W'(1))) begin
              half_nx = 1'b1;
              row_nx  = n_reg;
            end else if (!half) begin
              row_nx = row + N_W'(1);
            end else begin
              row_nx = row - N_W'(1);
            end
            state_nx = (row_space(n_reg, row_nx, half_nx) == '0) ? STAR : SPACE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so the byte appears together
  // with the state that presents it and holds unchanged through a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n_reg   <= '0;
      row     <= '0;
      col     <= '0;
      half    <= 1'b0;
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      n_reg   <= n_nx;
      row     <= row_nx;
      col     <= col_nx;
      half    <= half_nx;
      m_data  <= state_byte(state_nx);
      m_valid <= state_emits(state_nx);
      busy    <= (state_nx != IDLE);
      done    <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_diamond_char_gen.sv
// tb_diamond_char_gen: directed self-checking bench for diamond_char_gen.
module tb_diamond_char_gen;
  import diamond_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] n;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int          cyc = 0;
  logic        ready_level = 1'b1;
  logic        rand_ready  = 1'b0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          last_hs_edge = -1;
  int          busy_fall_cyc = -1;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  logic        busy_prev = 1'b0;

  diamond_char_gen #(.N_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .n       (n),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sink-side ready, changed only just after a rising edge.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      busy_prev  = 1'b0;
    end else begin
      if (stall_prev)
        check_eq("stall_hold", {23'd0, m_valid, m_data}, {23'd0, 1'b1, stall_data});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      busy_prev = busy;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        last_hs_edge = cyc + 1;
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  // Golden pattern built row by row from the textual description.
  function automatic void model_append(input int unsigned nv);
    for (int unsigned i = 0; i < nv; i++) begin
      for (int unsigned s = 0; s < nv - 1 - i; s++) exp_q.push_back(8'h20);
      for (int unsigned p = 0; p < i + 1; p++) begin
        exp_q.push_back(8'h2A);
        exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0A);
    end
    for (int unsigned k = nv; k >= 1; k--) begin
      for (int unsigned s = 0; s < nv - k; s++) exp_q.push_back(8'h20);
      for (int unsigned p = 0; p < k; p++) begin
        exp_q.push_back(8'h2A);
        exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic clear_run();
    got_q.delete();
    exp_q.delete();
    done_cnt      = 0;
    done_cyc      = -1;
    last_hs_edge  = -1;
    busy_fall_cyc = -1;
  endtask

  task automatic pulse_start(input logic [3:0] nv);
    start = 1'b1;
    n     = nv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic compare_stream(input string tag, input int exp_len);
    check_eq({tag, "_len"}, got_q.size(), exp_len);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check_eq({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      else check_eq({tag, "_missing"}, 32'd0, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    logic [7:0] n1_bytes[6];
    logic [7:0] n3_row0[5];
    logic [7:0] n3_wide[7];
    n1_bytes = '{8'h2A, 8'h20, 8'h0A, 8'h2A, 8'h20, 8'h0A};
    n3_row0  = '{8'h20, 8'h20, 8'h2A, 8'h20, 8'h0A};
    n3_wide  = '{8'h2A, 8'h20, 8'h2A, 8'h20, 8'h2A, 8'h20, 8'h0A};

    rst   = 1'b1;
    start = 1'b0;
    n     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_data", {24'd0, m_data}, 32'h00);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // n=1: content, first-byte latency, done/busy timing
    clear_run();
    pulse_start(4'd1);
    check_eq("n1_first_valid", {31'd0, m_valid}, 32'd1);
    check_eq("n1_first_busy", {31'd0, busy}, 32'd1);
    check_eq("n1_first_data", {24'd0, m_data}, 32'h2A);
    wait_idle(100);
    settle();
    check_eq("n1_len", got_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check_eq("n1_byte", {24'd0, got_q[i]}, {24'd0, n1_bytes[i]});
    check_eq("n1_done_cnt", done_cnt, 1);
    check_eq("n1_done_after_last", done_cyc, last_hs_edge);
    check_eq("n1_busy_fall", busy_fall_cyc, last_hs_edge + 1);

    // n=3, ready held high
    clear_run();
    model_append(3);
    pulse_start(4'd3);
    wait_idle(200);
    settle();
    compare_stream("n3", 36);
    for (int i = 0; i < 5; i++) begin
      check_eq("n3_row0", {24'd0, got_q[i]}, {24'd0, n3_row0[i]});
      check_eq("n3_row5", {24'd0, got_q[31 + i]}, {24'd0, n3_row0[i]});
    end
    for (int i = 0; i < 7; i++) begin
      check_eq("n3_row2", {24'd0, got_q[11 + i]}, {24'd0, n3_wide[i]});
      check_eq("n3_row3", {24'd0, got_q[18 + i]}, {24'd0, n3_wide[i]});
    end
    check_eq("n3_done_cnt", done_cnt, 1);

    // n=5 with random backpressure
    clear_run();
    model_append(5);
    rand_ready = 1'b1;
    pulse_start(4'd5);
    wait_idle(2000);
    rand_ready = 1'b0;
    settle();
    compare_stream("n5", 90);
    check_eq("n5_done_cnt", done_cnt, 1);

    // n=0: no bytes, done then idle
    clear_run();
    pulse_start(4'd0);
    check_eq("n0_valid", {31'd0, m_valid}, 32'd0);
    check_eq("n0_done_t1", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    check_eq("n0_busy_t2", {31'd0, busy}, 32'd0);
    check_eq("n0_done_t2", {31'd0, done}, 32'd0);
    settle();
    check_eq("n0_no_bytes", got_q.size(), 0);
    check_eq("n0_done_cnt", done_cnt, 1);

    // n=2 with an ignored start mid-pattern
    clear_run();
    model_append(2);
    pulse_start(4'd2);
    repeat (4) @(posedge clk);
    #1;
    pulse_start(4'd7);
    wait_idle(200);
    settle();
    compare_stream("n2_ign", 18);
    check_eq("n2_ign_done_cnt", done_cnt, 1);

    // reset after byte 10 of n=4
    clear_run();
    pulse_start(4'd4);
    for (int i = 0; i < 100 && got_q.size() < 10; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_valid", {31'd0, m_valid}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    settle();
    check_eq("abort_bytes", got_q.size(), 10);
    check_eq("abort_no_done", done_cnt, 0);

    // start together with reset is dropped
    rst   = 1'b1;
    start = 1'b1;
    n     = 4'd3;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_start_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_start_valid", {31'd0, m_valid}, 32'd0);

    // fresh n=2 after abort
    clear_run();
    model_append(2);
    pulse_start(4'd2);
    wait_idle(200);
    settle();
    compare_stream("n2_fresh", 18);

    // n=15 then n=1 at the first idle cycle
    clear_run();
    model_append(15);
    model_append(1);
    pulse_start(4'd15);
    wait_idle(2000);
    pulse_start(4'd1);
    wait_idle(100);
    settle();
    compare_stream("b2b", 726);
    check_eq("b2b_done_cnt", done_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
